// File: rtl/cv32e40p_apu_arbiter_if.sv
// ============================================================================
//  Module      : cv32e40p_apu_arbiter_if
//  Description : Bus bundles for the shared-APU arbiter. The core-side bundle
//                carries every core's request channel plus the broadcast
//                result. The APU-side bundle carries the single APU channel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cv32e40p_apu_arbiter_core_if #(
    parameter int NB_CORES = 4,
    parameter int NARGS    = 3,
    parameter int WOP      = 6,
    parameter int NDSFLAGS = 15,
    parameter int NUSFLAGS = 5
);
    logic [NB_CORES-1:0]                      core_req_i;
    logic [NB_CORES-1:0]                      core_gnt_o;
    logic [NB_CORES-1:0][NARGS-1:0][31:0]     core_operands_i;
    logic [NB_CORES-1:0][WOP-1:0]             core_op_i;
    logic [NB_CORES-1:0][NDSFLAGS-1:0]        core_flags_i;
    logic [NB_CORES-1:0]                      core_rvalid_o;
    logic [31:0]                              core_result_o;
    logic [NUSFLAGS-1:0]                      core_rflags_o;

    // Cores drive requests and receive grants/results
    modport master (
        output core_req_i, core_operands_i, core_op_i, core_flags_i,
        input  core_gnt_o, core_rvalid_o, core_result_o, core_rflags_o
    );

    // Arbiter receives requests and returns grants/results
    modport slave (
        input  core_req_i, core_operands_i, core_op_i, core_flags_i,
        output core_gnt_o, core_rvalid_o, core_result_o, core_rflags_o
    );
endinterface

interface cv32e40p_apu_arbiter_apu_if #(
    parameter int NARGS    = 3,
    parameter int WOP      = 6,
    parameter int NDSFLAGS = 15,
    parameter int NUSFLAGS = 5
);
    logic                       apu_req_o;
    logic                       apu_gnt_i;
    logic [NARGS-1:0][31:0]     apu_operands_o;
    logic [WOP-1:0]             apu_op_o;
    logic [NDSFLAGS-1:0]        apu_flags_o;
    logic                       apu_rvalid_i;
    logic [31:0]                apu_result_i;
    logic [NUSFLAGS-1:0]        apu_rflags_i;

    // Arbiter side: issues requests, receives results
    modport master (
        output apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
        input  apu_gnt_i, apu_rvalid_i, apu_result_i, apu_rflags_i
    );

    // APU side: accepts requests, returns results
    modport slave (
        input  apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
        output apu_gnt_i, apu_rvalid_i, apu_result_i, apu_rflags_i
    );
endinterface

`default_nettype wire

// File: rtl/cv32e40p_apu_arbiter.sv
// ============================================================================
//  Module      : cv32e40p_apu_arbiter
//  Description : Round-robin arbiter sharing one APU between NB_CORES cores.
//                Winner indices are kept in an in-order ID FIFO so each
//                returned result is steered back to the core that issued it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_apu_arbiter #(
    parameter int NB_CORES = 4,
    parameter int DEPTH    = 4,
    parameter int NARGS    = 3,
    parameter int WOP      = 6,
    parameter int NDSFLAGS = 15,
    parameter int NUSFLAGS = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cv32e40p_apu_arbiter_core_if.slave  core,
    cv32e40p_apu_arbiter_apu_if.master  apu,
    output logic [$clog2(DEPTH):0]      outstanding_o,
    output logic                        err_o
);
    localparam int IDW = $clog2(NB_CORES);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    logic [IDW-1:0] r_rr;
    logic [IDW-1:0] r_fifo [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           r_err;

    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_req;
    logic           w_issue;
    logic           w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_req   = (|core.core_req_i) && !w_full;
    assign w_issue = w_req && apu.apu_gnt_i;
    assign w_pop   = apu.apu_rvalid_i && !w_empty;
    assign w_head  = r_fifo[r_rptr];

    // Pick the first requester at or after the round-robin pointer; core 0 when idle
    always_comb begin
        logic found;
        int   k;
        found = 1'b0;
        k     = 0;
        w_win = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            k = (int'(r_rr) + i) % NB_CORES;
            if (!found && core.core_req_i[k]) begin
                found = 1'b1;
                w_win = IDW'(k);
            end
        end
    end

    assign apu.apu_req_o      = w_req;
    assign apu.apu_operands_o = core.core_operands_i[w_win];
    assign apu.apu_op_o       = core.core_op_i[w_win];
    assign apu.apu_flags_o    = core.core_flags_i[w_win];

    assign core.core_gnt_o    = w_issue ? (NB_CORES'(1) << w_win)  : '0;
    assign core.core_rvalid_o = w_pop   ? (NB_CORES'(1) << w_head) : '0;
    assign core.core_result_o = apu.apu_result_i;
    assign core.core_rflags_o = apu.apu_rflags_i;

    assign outstanding_o = r_count;
    assign err_o         = r_err;

    // Round-robin pointer, FIFO pointers, occupancy and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr    <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rr   <= (w_win == IDW'(NB_CORES - 1)) ? '0 : w_win + IDW'(1);
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_issue && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_issue && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            // A result with nothing outstanding (including a same-cycle push) is a protocol error
            if (apu.apu_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_fifo[r_wptr] <= w_win;
        end
    end

endmodule

`default_nettype wire
